serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial, LSB-first WIDTH-bit subtractor computing diff = a - b, with borrow-out.
//   One half-subtractor-style full-subtract cell is reused each clock; state is held in
//   shift registers, a borrow flop and a bit counter.
//   Sits after operand capture in the arithmetic datapath. A start/busy/done handshake
//   sequences each operation.
// PARAMETERS
//   WIDTH  8  operand and result width in bits (>= 2)
// PORTS
//   clk         input   1      rising-edge clock; the only clock
//   rst         input   1      synchronous, active-high reset
//   start       input   1      one-cycle request; a/b sampled when accepted
//   a           input   WIDTH  minuend
//   b           input   WIDTH  subtrahend
//   busy        output  1      high while bits are being processed
//   done        output  1      one-cycle pulse: diff/borrow_out valid
//   diff        output  WIDTH  a - b modulo 2^WIDTH; held until next accepted start
//   borrow_out  output  1      1 when a < b (unsigned); held with diff
// BEHAVIOUR
//   Reset: rst sampled high at a rising edge gives state=IDLE, busy=0, done=0, diff=0,
//     borrow_out=0, bit count=0, internal shift regs=0. Reset overrides start.
//   FSM states: IDLE, SHIFT, DONE.
//     IDLE : start=1 -> load a_sr<=a, b_sr<=b, brw<=0, cnt<=0; go to SHIFT.
//            start=0 -> stay in IDLE.
//     SHIFT: busy=1. Each cycle:
//              d      = a_sr[0] ^ b_sr[0] ^ brw
//              brw'   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw)
//            d shifts into the result reg at the MSB (result shifts right); a_sr and b_sr
//            shift right; cnt increments. After the WIDTH-th bit (cnt==WIDTH-1), go to DONE.
//     DONE : done=1 for exactly this cycle. diff=result, borrow_out=final brw (both
//            registered on entry). start=1 here is accepted like IDLE (back-to-back).
//            Otherwise go to IDLE.
//   Latency: start accepted at edge N -> done high during the cycle after edge N+WIDTH.
//     That is WIDTH+1 cycles from start to done. Throughput: one op per WIDTH+1 cycles.
//   start while in SHIFT is ignored: no reload, no effect on the running op.
//   a/b are sampled only at acceptance; changes during SHIFT have no effect.
//   diff/borrow_out change only on entry to DONE or on reset. Between ops they hold the
//     last result.
//   rst asserted mid-SHIFT aborts the op. No done pulse; all outputs return to reset values.
//   Unsigned semantics: borrow_out=1 iff a<b. diff wraps modulo 2^WIDTH.
// TESTING (WIDTH=8)
//   1. Hold rst 2 cycles, then a=5, b=3, start pulse -> done after 9 cycles; diff=8'h02,
//      borrow_out=0. busy is high for exactly 8 cycles.
//   2. a=8'h03, b=8'h05 -> diff=8'hFE, borrow_out=1. Then a=8'h00, b=8'h01 -> diff=8'hFF,
//      borrow_out=1.
//   3. a=8'hFF, b=8'hFF -> diff=8'h00, borrow_out=0. Then a=8'hA5, b=8'h00 -> diff=8'hA5,
//      borrow_out=0.
//   4. Start a=9, b=4. Pulse start with a=1, b=1 and change a/b 3 cycles later ->
//      diff=8'h05, one done pulse only.
//   5. Start a=8'h10, b=8'h01. Assert rst at cycle 4 of SHIFT -> no done; busy=0, diff=0,
//      borrow_out=0. A new start then completes normally.
//   6. Hold start high through a DONE cycle -> second op starts immediately. Done pulses
//      9 cycles apart.
//      Also: random a/b x1000 vs (a-b), with borrow_out checked as a<b.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//
// Bit-serial, LSB-first unsigned subtractor producing diff = a - b (mod 2^WIDTH)
// and a borrow flag.
//
// Structure:
//   - One full-subtract cell, reused on every clock.
//   - Shift registers hold both operands and the partial result.
//   - A borrow flop and a bit counter complete the state.
//   - A start/busy/done handshake sequences each operation.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       one-cycle request; a/b are sampled when it is accepted
//   a           minuend (WIDTH bits)
//   b           subtrahend (WIDTH bits)
//   busy        high while operand bits are being processed
//   done        one-cycle pulse when diff/borrow_out hold a fresh result
//   diff        a - b modulo 2^WIDTH, held until the next result
//   borrow_out  1 when a < b (unsigned), held with diff

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] result;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             load;
    logic             last_bit;
    logic             d;
    logic             brw_next;
    logic [WIDTH-1:0] result_next;

    // The single full-subtract cell. It works on the current LSBs of both
    // operands plus the borrow carried in from the previous bit. A borrow
    // comes out when the minuend bit is 0 and the subtrahend bit is 1. When
    // both bits are equal, the incoming borrow passes straight through.
    always_comb begin
        d           = a_sr[0] ^ b_sr[0] ^ brw;
        brw_next    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
        result_next = {d, result[WIDTH-1:1]};
    end

    // Next-state logic and control strobes.
    // The DONE state accepts a new start exactly like IDLE, which lets
    // operations run back-to-back. A start seen during SHIFT is ignored, so
    // the running operation cannot be disturbed.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        last_bit   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST_BIT) begin
                    last_bit   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register. Reset is synchronous, and it wins over any pending
    // start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers.
    // On acceptance, the operands are captured and the borrow and counter
    // are cleared. During SHIFT, one bit is processed per clock:
    //   - the difference bit enters the result at the MSB;
    //   - everything shifts right, so after WIDTH clocks the LSB-first
    //     stream sits in the correct bit positions.
    // The visible outputs are updated only on the clock that moves into
    // DONE. That clock folds in the final bit straight from the cell, so
    // the outputs never show a partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            result     <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            if (load) begin
                a_sr   <= a;
                b_sr   <= b;
                result <= '0;
                brw    <= 1'b0;
                cnt    <= '0;
            end else if (state == SHIFT) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                result <= result_next;
                brw    <= brw_next;
                cnt    <= cnt + CW'(1);
            end

            if (last_bit) begin
                diff       <= result_next;
                borrow_out <= brw_next;
            end
        end
    end

    // Handshake outputs come straight from the registered state.
    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor with WIDTH = 8.
//
// Checks covered:
//   - reset values;
//   - a table of directed operand pairs with hand-computed results;
//   - hand-written sequences for the multi-cycle corner cases: start
//     during SHIFT, reset mid-operation, back-to-back start;
//   - random operand pairs checked against a plain-arithmetic model.
//
// Timing: inputs are driven and outputs sampled on the falling edge, away
// from the active rising edge.

module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam int LATENCY = WIDTH + 1;
    localparam int BOUND = 40;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    int compared;
    int mismatched;

    typedef struct {
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        logic [WIDTH-1:0] exp_diff;
        logic             exp_borrow;
    } vector_t;

    vector_t vectors[8];

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every comparison and reports each
    // failure on one line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Runs one complete operation, starting from IDLE at a falling edge.
    // It checks:
    //   - latency and busy length;
    //   - the result and borrow;
    //   - that done lasts a single cycle;
    //   - that the result is held afterwards.
    task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                                 input logic [WIDTH-1:0] exp_diff, input logic exp_borrow);
        int  lat;
        int  busy_cnt;
        logic seen_done;
        lat      = -1;
        busy_cnt = 0;
        a        = ta;
        b        = tb_;
        start    = 1'b1;
        for (int k = 1; k <= BOUND; k++) begin
            @(negedge clk);
            seen_done = done;
            if (busy) busy_cnt++;
            start = 1'b0;
            if (seen_done) begin
                lat = k;
                break;
            end
        end
        checkOutput("latency", lat, LATENCY);
        checkOutput("busy_cycles", busy_cnt, WIDTH);
        checkOutput("diff", 32'(diff), 32'(exp_diff));
        checkOutput("borrow_out", 32'(borrow_out), 32'(exp_borrow));
        @(negedge clk);
        checkOutput("done_single_cycle", 32'(done), 0);
        checkOutput("diff_held", 32'(diff), 32'(exp_diff));
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [WIDTH-1:0] model_diff;
        logic             model_borrow;
        int               first_done;
        int               second_done;
        int               done_count;

        compared   = 0;
        mismatched = 0;

        // Directed operand pairs with hand-computed results.
        vectors[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
        vectors[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
        vectors[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vectors[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vectors[4] = '{8'hA5, 8'h00, 8'hA5, 1'b0};
        vectors[5] = '{8'h80, 8'h7F, 8'h01, 1'b0};
        vectors[6] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
        vectors[7] = '{8'h00, 8'hFF, 8'h01, 1'b1};

        // Reset held for two cycles; all outputs must be at their reset
        // values.
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h00;
        b     = 8'h00;
        repeat (2) @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_diff", 32'(diff), 0);
        checkOutput("reset_borrow", 32'(borrow_out), 0);
        @(negedge clk);
        checkOutput("reset_idle_busy", 32'(busy), 0);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vectors[i].va, vectors[i].vb,
                          vectors[i].exp_diff, vectors[i].exp_borrow);
        end

        // Start pulsed during SHIFT and operands changed mid-operation:
        // neither may affect the running 9 - 4.
        a          = 8'h09;
        b          = 8'h04;
        start      = 1'b1;
        first_done = -1;
        done_count = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) begin
                done_count++;
                if (first_done < 0) first_done = k;
            end
            if (k == 1) begin
                a     = 8'h01;
                b     = 8'h01;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (k == 4) begin
                a = 8'hFF;
                b = 8'hAA;
            end
            if (first_done == k) begin
                checkOutput("ignore_start_diff", 32'(diff), 32'h05);
                checkOutput("ignore_start_borrow", 32'(borrow_out), 0);
            end
        end
        checkOutput("ignore_start_latency", first_done, LATENCY);
        checkOutput("ignore_start_done_count", done_count, 1);

        // Reset in the fourth SHIFT cycle aborts the operation: no done
        // pulse, and all outputs return to their reset values.
        a          = 8'h10;
        b          = 8'h01;
        start      = 1'b1;
        done_count = 0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort_busy_before", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_diff", 32'(diff), 0);
        checkOutput("abort_borrow", 32'(borrow_out), 0);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) done_count++;
        end
        checkOutput("abort_no_done", done_count, 0);
        applyStimulus(8'h10, 8'h01, 8'h0F, 1'b0);

        // Start held high through DONE: the second operation begins at
        // once, so the done pulses are LATENCY cycles apart.
        a           = 8'h14;
        b           = 8'h03;
        start       = 1'b1;
        first_done  = -1;
        second_done = -1;
        for (int k = 1; k <= BOUND; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a = 8'h03;
                b = 8'h14;
            end
            if (done && first_done < 0) begin
                first_done = k;
                checkOutput("b2b_first_diff", 32'(diff), 32'h11);
                checkOutput("b2b_first_borrow", 32'(borrow_out), 0);
            end else if (done && second_done < 0) begin
                second_done = k;
                checkOutput("b2b_second_diff", 32'(diff), 32'hEF);
                checkOutput("b2b_second_borrow", 32'(borrow_out), 1);
                break;
            end
            if (first_done >= 0 && k == first_done + 1) start = 1'b0;
        end
        start = 1'b0;
        checkOutput("b2b_first_latency", first_done, LATENCY);
        checkOutput("b2b_spacing", second_done - first_done, LATENCY);
        @(negedge clk);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 1000; i++) begin
            ra           = WIDTH'($urandom);
            rb           = WIDTH'($urandom);
            model_diff   = WIDTH'((int'(ra) - int'(rb)) & ((1 << WIDTH) - 1));
            model_borrow = (int'(ra) < int'(rb));
            applyStimulus(ra, rb, model_diff, model_borrow);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
